// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit: PC select encoding, PC increment, clog2.
package npc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_CALL = 3'd2,
        SEL_RET  = 3'd3,
        SEL_HOLD = 3'd4
    } pc_sel_e;

    localparam int unsigned PC_INC = 4;

    // Ceiling log2 for sizing pointers and counters (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the write pointer marks the next free slot and the
// top of stack is the slot just below it. When the stack is full a push overwrites
// the oldest entry. ovf/unf are single-cycle event strobes for the cycle in which the
// corresponding push/pop/replace request is applied.
module ras_stack
    import npc_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        replace,
    input  logic [W-1:0]                din,
    output logic [W-1:0]                top,
    output logic [clog2(RAS_DEPTH):0]   count,
    output logic                        ovf,
    output logic                        unf
);

    localparam int unsigned PW = clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  entry_q [RAS_DEPTH];
    logic [W-1:0]  entry_d [RAS_DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] top_idx;
    logic          empty;
    logic          full;

    assign top_idx = wp_q - PW'(1);
    assign empty   = (count_q == CW'(0));
    assign full    = (count_q == CW'(RAS_DEPTH));
    assign top     = entry_q[top_idx];
    assign count   = count_q;

    // Next-state for entries, pointer and count, plus overflow/underflow events.
    always_comb begin
        entry_d = entry_q;
        wp_d    = wp_q;
        count_d = count_q;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (replace) begin
            if (empty) begin
                // Nothing to return to: behaves as a push and flags the underflow.
                entry_d[wp_q] = din;
                wp_d          = wp_q + PW'(1);
                count_d       = count_q + CW'(1);
                unf           = 1'b1;
            end else begin
                entry_d[top_idx] = din;
            end
        end else if (push) begin
            entry_d[wp_q] = din;
            wp_d          = wp_q + PW'(1);
            if (full) begin
                ovf = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf = 1'b1;
            end else begin
                wp_d    = wp_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end
    end

    // Stack state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                entry_q[i] <= '0;
            end
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator: priority mux over hold/return/call/branch/sequential with a
// return-address stack. Build option NPC_RAS_ERR_EN adds a sticky RAS error flag;
// without it ras_err is tied low.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int unsigned   W            = 32,
    parameter int unsigned   RAS_DEPTH    = 4,
    parameter logic [W-1:0]  RESET_VECTOR = '0
) (
    input  logic                        clk,
    input  logic                        reset_synchronous,
    input  logic                        stall,
    input  logic [W-1:0]                pc_current,
    input  logic                        branch_taken,
    input  logic [W-1:0]                branch_target,
    input  logic                        is_call,
    input  logic                        is_ret,
    output logic [W-1:0]                pc_next,
    output logic [clog2(RAS_DEPTH):0]   ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_err
);

    localparam int unsigned CW = clog2(RAS_DEPTH) + 1;

    pc_sel_e       sel;
    logic [W-1:0]  pc_inc;
    logic [W-1:0]  tgt_aligned;
    logic [W-1:0]  ras_top;
    logic          ras_go;
    logic          ras_push;
    logic          ras_pop;
    logic          ras_replace;
    logic          ras_ovf;
    logic          ras_unf;
    logic          tgt_lsb_unused;

    // Targets are word aligned; the low bits of branch_target are dropped.
    assign pc_inc         = pc_current + W'(PC_INC);
    assign tgt_aligned    = {branch_target[W-1:2], 2'b00};
    assign tgt_lsb_unused = ^branch_target[1:0];

    // Stack requests only when neither stalled nor in reset.
    assign ras_go      = ~reset_synchronous & ~stall;
    assign ras_push    = ras_go & is_call & ~is_ret;
    assign ras_pop     = ras_go & is_ret & ~is_call;
    assign ras_replace = ras_go & is_call & is_ret;

    // Select priority: stall > ret > call > branch > sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (is_ret) begin
            sel = SEL_RET;
        end else if (is_call) begin
            sel = SEL_CALL;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    // Next-PC mux; an empty stack on return falls through to pc+4.
    always_comb begin
        pc_next = pc_inc;
        if (reset_synchronous) begin
            pc_next = RESET_VECTOR;
        end else begin
            unique case (sel)
                SEL_HOLD: pc_next = pc_current;
                SEL_RET:  pc_next = ras_empty ? pc_inc : ras_top;
                SEL_CALL: pc_next = tgt_aligned;
                SEL_BR:   pc_next = tgt_aligned;
                default:  pc_next = pc_inc;
            endcase
        end
    end

    ras_stack #(
        .W         (W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (reset_synchronous),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .din     (pc_inc),
        .top     (ras_top),
        .count   (ras_count),
        .ovf     (ras_ovf),
        .unf     (ras_unf)
    );

    assign ras_empty = (ras_count == CW'(0));
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));

`ifdef NPC_RAS_ERR_EN
    logic err_q, err_d;

    // Sticky error: any overflow or underflow holds the flag until reset.
    always_comb begin
        err_d = err_q | ras_ovf | ras_unf;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset_synchronous) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ras_err = err_q;
`else
    logic err_unused;

    assign err_unused = ras_ovf | ras_unf;
    assign ras_err    = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit with a queue-based scoreboard: the driver pushes the
// hand-computed expectation for each driven cycle, the monitor pops and compares at
// the falling edge.
module tb_next_pc_unit;

`ifdef NPC_RAS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_synchronous;
    logic        stall;
    logic [31:0] pc_current;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        is_call;
    logic        is_ret;
    logic [31:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    next_pc_unit #(
        .W            (32),
        .RAS_DEPTH    (4),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk               (clk),
        .reset_synchronous (reset_synchronous),
        .stall             (stall),
        .pc_current        (pc_current),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .is_call           (is_call),
        .is_ret            (is_ret),
        .pc_next           (pc_next),
        .ras_count         (ras_count),
        .ras_empty         (ras_empty),
        .ras_full          (ras_full),
        .ras_err           (ras_err)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        int unsigned cnt;
        bit          err;
        bit          chk_st;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vid      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue its expected response.
    task automatic vec(input bit r, input bit s, input logic [31:0] pc,
                       input bit br, input logic [31:0] tgt,
                       input bit c, input bit t,
                       input logic [31:0] epc, input int unsigned ecnt,
                       input bit eerr, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        reset_synchronous = r;
        stall             = s;
        pc_current        = pc;
        branch_taken      = br;
        branch_target     = tgt;
        is_call           = c;
        is_ret            = t;
        e.id     = vid;
        e.pc     = epc;
        e.cnt    = ecnt;
        e.err    = ERR_EN & eerr;
        e.chk_st = chk;
        sb_q.push_back(e);
        vid++;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (pc_next !== e.pc) begin
                n_fail++;
                $display("FAIL vec%0d pc_next: got %h expected %h", e.id, pc_next, e.pc);
            end
            if (e.chk_st) begin
                n_checks++;
                if (ras_count !== 3'(e.cnt)) begin
                    n_fail++;
                    $display("FAIL vec%0d ras_count: got %0d expected %0d", e.id, ras_count, e.cnt);
                end
                n_checks++;
                if (ras_empty !== (e.cnt == 0)) begin
                    n_fail++;
                    $display("FAIL vec%0d ras_empty: got %b expected %b", e.id, ras_empty, (e.cnt == 0));
                end
                n_checks++;
                if (ras_full !== (e.cnt == 4)) begin
                    n_fail++;
                    $display("FAIL vec%0d ras_full: got %b expected %b", e.id, ras_full, (e.cnt == 4));
                end
                n_checks++;
                if (ras_err !== e.err) begin
                    n_fail++;
                    $display("FAIL vec%0d ras_err: got %b expected %b", e.id, ras_err, e.err);
                end
            end
        end
    end

    initial begin
        reset_synchronous = 1'b1;
        stall             = 1'b0;
        pc_current        = 32'h0;
        branch_taken      = 1'b0;
        branch_target     = 32'h0;
        is_call           = 1'b0;
        is_ret            = 1'b0;

        //  rst stl pc            br tgt          c  r  exp_pc        cnt err chk
        // Reset
        vec(1, 0, 32'h40,        0, 32'h0,       0, 0, 32'h0,        0, 0, 0);
        vec(1, 0, 32'h40,        0, 32'h0,       0, 0, 32'h0,        0, 0, 1);
        // Sequential and branch
        vec(0, 0, 32'h100,       0, 32'h0,       0, 0, 32'h104,      0, 0, 1);
        vec(0, 0, 32'h100,       1, 32'h203,     0, 0, 32'h200,      0, 0, 1);
        // Call / ret
        vec(0, 0, 32'h10,        0, 32'h80,      1, 0, 32'h80,       0, 0, 1);
        vec(0, 0, 32'h80,        0, 32'h0,       0, 0, 32'h84,       1, 0, 1);
        vec(0, 0, 32'h90,        0, 32'h0,       0, 1, 32'h14,       1, 0, 1);
        vec(0, 0, 32'h14,        0, 32'h0,       0, 0, 32'h18,       0, 0, 1);
        // Overflow: five calls into a four-deep stack
        vec(0, 0, 32'h0,         0, 32'h100,     1, 0, 32'h100,      0, 0, 1);
        vec(0, 0, 32'h4,         0, 32'h100,     1, 0, 32'h100,      1, 0, 1);
        vec(0, 0, 32'h8,         0, 32'h100,     1, 0, 32'h100,      2, 0, 1);
        vec(0, 0, 32'hC,         0, 32'h100,     1, 0, 32'h100,      3, 0, 1);
        vec(0, 0, 32'h10,        0, 32'h100,     1, 0, 32'h100,      4, 0, 1);
        vec(0, 0, 32'h200,       0, 32'h0,       0, 1, 32'h14,       4, 1, 1);
        vec(0, 0, 32'h200,       0, 32'h0,       0, 1, 32'h10,       3, 1, 1);
        vec(0, 0, 32'h200,       0, 32'h0,       0, 1, 32'hC,        2, 1, 1);
        vec(0, 0, 32'h200,       0, 32'h0,       0, 1, 32'h8,        1, 1, 1);
        vec(0, 0, 32'h200,       0, 32'h0,       0, 0, 32'h204,      0, 1, 1);
        // Underflow after clearing the error
        vec(1, 0, 32'h40,        0, 32'h0,       0, 0, 32'h0,        0, 1, 1);
        vec(0, 0, 32'h20,        0, 32'h0,       0, 1, 32'h24,       0, 0, 1);
        vec(0, 0, 32'h24,        0, 32'h0,       0, 0, 32'h28,       0, 1, 1);
        // Stall + call holds PC and leaves the stack alone
        vec(0, 1, 32'h50,        0, 32'h300,     1, 0, 32'h50,       0, 1, 1);
        vec(0, 0, 32'h50,        0, 32'h0,       0, 0, 32'h54,       0, 1, 1);
        // Stall + ret on empty raises no underflow
        vec(1, 0, 32'h40,        0, 32'h0,       0, 0, 32'h0,        0, 1, 1);
        vec(0, 1, 32'h60,        0, 32'h0,       0, 1, 32'h60,       0, 0, 1);
        vec(0, 0, 32'h60,        0, 32'h0,       0, 0, 32'h64,       0, 0, 1);
        // Address wrap
        vec(0, 0, 32'hFFFF_FFFC, 0, 32'h0,       0, 0, 32'h0,        0, 0, 1);
        // Simultaneous call+ret with a non-empty stack
        vec(0, 0, 32'h4C,        0, 32'h300,     1, 0, 32'h300,      0, 0, 1);
        vec(0, 0, 32'h30,        0, 32'h400,     1, 1, 32'h50,       1, 0, 1);
        vec(0, 0, 32'h500,       0, 32'h0,       0, 1, 32'h34,       1, 0, 1);
        vec(0, 0, 32'h34,        0, 32'h0,       0, 0, 32'h38,       0, 0, 1);
        // Simultaneous call+ret on empty: push plus underflow
        vec(0, 0, 32'h70,        0, 32'h400,     1, 1, 32'h74,       0, 0, 1);
        vec(0, 0, 32'h100,       0, 32'h0,       0, 0, 32'h104,      1, 1, 1);
        vec(0, 0, 32'h100,       0, 32'h0,       0, 1, 32'h74,       1, 1, 1);
        // Reset mid-sequence discards entries
        vec(0, 0, 32'h8,         0, 32'h10,      1, 0, 32'h10,       0, 1, 1);
        vec(1, 0, 32'h10,        0, 32'h0,       0, 0, 32'h0,        1, 1, 1);
        vec(0, 0, 32'h44,        0, 32'h0,       0, 1, 32'h48,       0, 0, 1);

        @(posedge clk);
        #1;
        is_call = 1'b0;
        is_ret  = 1'b0;
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
